// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code sequencer: pops bytes from the receive FIFO, decodes set-2
// make/break/extended sequences and holds key state for the display path.
module ps2_key_ctrl #(
    parameter int COUNT_W       = 8,
    parameter bit REPEAT_COUNTS = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               ps2_ready_i,
    input  logic [7:0]         ps2_data_i,
    input  logic               ps2_overflow_i,
    output logic               ps2_nextdata_n_o,
    output logic [7:0]         key_code_o,
    output logic               key_ext_o,
    output logic               key_held_o,
    output logic [7:0]         ascii_o,
    output logic [COUNT_W-1:0] press_count_o,
    output logic               err_overflow_o
);

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_POP    = 2'd1,
        S_DECODE = 2'd2
    } state_t;

    state_t             state_q;
    logic [7:0]         rx_byte_q;
    logic               nextdata_n_q;
    logic [7:0]         key_code_q;
    logic               key_ext_q;
    logic               key_held_q;
    logic [7:0]         ascii_q;
    logic [COUNT_W-1:0] press_count_q;
    logic               err_overflow_q;
    logic               break_pend_q;
    logic               ext_pend_q;

    logic [7:0]         ascii_d;
    logic               same_key_d;

    // Set-2 letters, digits and space; extended codes never map.
    always_comb begin
        ascii_d = 8'h00;
        if (!ext_pend_q) begin
            case (rx_byte_q)
                8'h1C: ascii_d = 8'h61;  8'h32: ascii_d = 8'h62;
                8'h21: ascii_d = 8'h63;  8'h23: ascii_d = 8'h64;
                8'h24: ascii_d = 8'h65;  8'h2B: ascii_d = 8'h66;
                8'h34: ascii_d = 8'h67;  8'h33: ascii_d = 8'h68;
                8'h43: ascii_d = 8'h69;  8'h3B: ascii_d = 8'h6A;
                8'h42: ascii_d = 8'h6B;  8'h4B: ascii_d = 8'h6C;
                8'h3A: ascii_d = 8'h6D;  8'h31: ascii_d = 8'h6E;
                8'h44: ascii_d = 8'h6F;  8'h4D: ascii_d = 8'h70;
                8'h15: ascii_d = 8'h71;  8'h2D: ascii_d = 8'h72;
                8'h1B: ascii_d = 8'h73;  8'h2C: ascii_d = 8'h74;
                8'h3C: ascii_d = 8'h75;  8'h2A: ascii_d = 8'h76;
                8'h1D: ascii_d = 8'h77;  8'h22: ascii_d = 8'h78;
                8'h35: ascii_d = 8'h79;  8'h1A: ascii_d = 8'h7A;
                8'h45: ascii_d = 8'h30;  8'h16: ascii_d = 8'h31;
                8'h1E: ascii_d = 8'h32;  8'h26: ascii_d = 8'h33;
                8'h25: ascii_d = 8'h34;  8'h2E: ascii_d = 8'h35;
                8'h36: ascii_d = 8'h36;  8'h3D: ascii_d = 8'h37;
                8'h3E: ascii_d = 8'h38;  8'h46: ascii_d = 8'h39;
                8'h29: ascii_d = 8'h20;
                default: ascii_d = 8'h00;
            endcase
        end
    end

    assign same_key_d = (rx_byte_q == key_code_q) && (ext_pend_q == key_ext_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= S_WAIT;
            rx_byte_q      <= 8'h00;
            nextdata_n_q   <= 1'b1;
            key_code_q     <= 8'h00;
            key_ext_q      <= 1'b0;
            key_held_q     <= 1'b0;
            ascii_q        <= 8'h00;
            press_count_q  <= '0;
            err_overflow_q <= 1'b0;
            break_pend_q   <= 1'b0;
            ext_pend_q     <= 1'b0;
        end else begin
            if (ps2_overflow_i)
                err_overflow_q <= 1'b1;
            case (state_q)
                S_WAIT: begin
                    if (ps2_ready_i) begin
                        rx_byte_q    <= ps2_data_i;
                        nextdata_n_q <= 1'b0;
                        state_q      <= S_POP;
                    end
                end
                S_POP: begin
                    nextdata_n_q <= 1'b1;
                    state_q      <= S_DECODE;
                end
                S_DECODE: begin
                    state_q <= S_WAIT;
                    if (rx_byte_q == 8'hE0) begin
                        ext_pend_q <= 1'b1;
                    end else if (rx_byte_q == 8'hF0) begin
                        break_pend_q <= 1'b1;
                    end else if (break_pend_q) begin
                        // Releasing a key other than the current one is ignored.
                        if (same_key_d)
                            key_held_q <= 1'b0;
                        break_pend_q <= 1'b0;
                        ext_pend_q   <= 1'b0;
                    end else begin
                        if (!key_held_q || !same_key_d) begin
                            key_code_q    <= rx_byte_q;
                            key_ext_q     <= ext_pend_q;
                            key_held_q    <= 1'b1;
                            ascii_q       <= ascii_d;
                            press_count_q <= press_count_q + COUNT_W'(1);
                        end else if (REPEAT_COUNTS) begin
                            press_count_q <= press_count_q + COUNT_W'(1);
                        end
                        ext_pend_q <= 1'b0;
                    end
                end
                default: state_q <= S_WAIT;
            endcase
        end
    end

    assign ps2_nextdata_n_o = nextdata_n_q;
    assign key_code_o       = key_code_q;
    assign key_ext_o        = key_ext_q;
    assign key_held_o       = key_held_q;
    assign ascii_o          = ascii_q;
    assign press_count_o    = press_count_q;
    assign err_overflow_o   = err_overflow_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Self-checking bench for ps2_key_ctrl: FIFO model, reference key model and
// scoreboard; two instances differ only in REPEAT_COUNTS and run in lockstep.
module tb_ps2_key_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_ready = 1'b0;
    logic [7:0] ps2_data = 8'h00;
    logic       ps2_overflow = 1'b0;

    logic       nd_n, nd_n_r;
    logic [7:0] key_code, key_code_r;
    logic       key_ext, key_ext_r;
    logic       key_held, key_held_r;
    logic [7:0] ascii, ascii_r;
    logic [7:0] cnt, cnt_r;
    logic       err_ov, err_ov_r;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ps2_key_ctrl #(.COUNT_W(8), .REPEAT_COUNTS(1'b0)) dut (
        .clk_i(clk), .rst_i(rst), .ps2_ready_i(ps2_ready), .ps2_data_i(ps2_data),
        .ps2_overflow_i(ps2_overflow), .ps2_nextdata_n_o(nd_n),
        .key_code_o(key_code), .key_ext_o(key_ext), .key_held_o(key_held),
        .ascii_o(ascii), .press_count_o(cnt), .err_overflow_o(err_ov));

    ps2_key_ctrl #(.COUNT_W(8), .REPEAT_COUNTS(1'b1)) dut_r (
        .clk_i(clk), .rst_i(rst), .ps2_ready_i(ps2_ready), .ps2_data_i(ps2_data),
        .ps2_overflow_i(ps2_overflow), .ps2_nextdata_n_o(nd_n_r),
        .key_code_o(key_code_r), .key_ext_o(key_ext_r), .key_held_o(key_held_r),
        .ascii_o(ascii_r), .press_count_o(cnt_r), .err_overflow_o(err_ov_r));

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       held;
        logic [7:0] asc;
        logic [7:0] cnt;
        logic [7:0] cnt_r;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo[$];
    int         pop_cyc[$];
    int         cyc = 0;
    int         dec_cnt = 0;
    logic       prev_low = 1'b0;

    // Reference model state
    logic [7:0] m_code, m_asc, m_cnt, m_cnt_r;
    logic       m_ext, m_held, m_brk, m_epd;

    function automatic logic [7:0] amap(input logic [7:0] b);
        case (b)
            8'h1C: return 8'h61; 8'h32: return 8'h62; 8'h21: return 8'h63;
            8'h23: return 8'h64; 8'h24: return 8'h65; 8'h2B: return 8'h66;
            8'h34: return 8'h67; 8'h33: return 8'h68; 8'h43: return 8'h69;
            8'h3B: return 8'h6A; 8'h42: return 8'h6B; 8'h4B: return 8'h6C;
            8'h3A: return 8'h6D; 8'h31: return 8'h6E; 8'h44: return 8'h6F;
            8'h4D: return 8'h70; 8'h15: return 8'h71; 8'h2D: return 8'h72;
            8'h1B: return 8'h73; 8'h2C: return 8'h74; 8'h3C: return 8'h75;
            8'h2A: return 8'h76; 8'h1D: return 8'h77; 8'h22: return 8'h78;
            8'h35: return 8'h79; 8'h1A: return 8'h7A;
            8'h45: return 8'h30; 8'h16: return 8'h31; 8'h1E: return 8'h32;
            8'h26: return 8'h33; 8'h25: return 8'h34; 8'h2E: return 8'h35;
            8'h36: return 8'h36; 8'h3D: return 8'h37; 8'h3E: return 8'h38;
            8'h46: return 8'h39; 8'h29: return 8'h20;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_code = 8'h00; m_asc = 8'h00; m_cnt = 8'h00; m_cnt_r = 8'h00;
        m_ext = 1'b0; m_held = 1'b0; m_brk = 1'b0; m_epd = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        exp_t e;
        if (b == 8'hE0) m_epd = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (m_brk) begin
            if (b == m_code && m_epd == m_ext) m_held = 1'b0;
            m_brk = 1'b0;
            m_epd = 1'b0;
        end else begin
            if (!m_held || b != m_code || m_epd != m_ext) begin
                m_code = b;
                m_ext  = m_epd;
                m_held = 1'b1;
                m_asc  = m_epd ? 8'h00 : amap(b);
                m_cnt  = m_cnt + 8'd1;
            end
            m_cnt_r = m_cnt_r + 8'd1;
            m_epd   = 1'b0;
        end
        e.code = m_code; e.ext = m_ext; e.held = m_held;
        e.asc = m_asc; e.cnt = m_cnt; e.cnt_r = m_cnt_r;
        exp_q.push_back(e);
        fifo.push_back(b);
    endtask

    // FIFO model, pop-pulse monitor and scoreboard compare
    always @(negedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        if (rst) begin
            dec_cnt = 0;
        end else if (dec_cnt > 0) begin
            dec_cnt = dec_cnt - 1;
            if (dec_cnt == 0) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL decode_unexpected: decode seen with empty scoreboard");
                end else begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if ({key_code, key_ext, key_held, ascii, cnt} !== {e.code, e.ext, e.held, e.asc, e.cnt})
                        $display("FAIL decode: got code=%h ext=%b held=%b ascii=%h cnt=%0d exp code=%h ext=%b held=%b ascii=%h cnt=%0d",
                                 key_code, key_ext, key_held, ascii, cnt, e.code, e.ext, e.held, e.asc, e.cnt);
                    else n_pass++;
                    n_checks++;
                    if ({key_code_r, key_held_r, cnt_r} !== {e.code, e.held, e.cnt_r})
                        $display("FAIL decode_rep: got code=%h held=%b cnt=%0d exp code=%h held=%b cnt=%0d",
                                 key_code_r, key_held_r, cnt_r, e.code, e.held, e.cnt_r);
                    else n_pass++;
                end
            end
        end
        if (nd_n === 1'b0) begin
            n_checks++;
            if (prev_low) $display("FAIL pop_width: nextdata_n low 2 cycles, exp 1");
            else n_pass++;
            if (fifo.size() != 0) void'(fifo.pop_front());
            pop_cyc.push_back(cyc);
            dec_cnt = 2;
        end
        prev_low  = (nd_n === 1'b0);
        ps2_ready = (fifo.size() != 0);
        ps2_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    end

    task automatic wait_idle();
        int t = 0;
        while ((fifo.size() != 0 || exp_q.size() != 0 || dec_cnt != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            n_checks++;
            $display("FAIL idle_timeout: fifo=%0d pending=%0d exp 0 0", fifo.size(), exp_q.size());
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        model_reset();
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        fifo.push_back(8'h1C);
        repeat (3) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (nd_n !== 1'b1) $display("FAIL reset_pop: nextdata_n=%b exp 1", nd_n);
            else n_pass++;
        end
        n_checks++;
        if (ps2_ready !== 1'b1) $display("FAIL reset_ready: ready=%b exp 1", ps2_ready);
        else n_pass++;
        n_checks++;
        if ({key_code, key_ext, key_held, ascii, cnt, err_ov} !== 26'd0 || cnt_r !== 8'd0)
            $display("FAIL reset_vals: code=%h ext=%b held=%b ascii=%h cnt=%0d err=%b exp all 0",
                     key_code, key_ext, key_held, ascii, cnt, err_ov);
        else n_pass++;
        fifo.delete();
        @(negedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        wait_idle();
    endtask

    task automatic test_press_a();
        pop_cyc.delete();
        send(8'h1C); send(8'hF0); send(8'h1C);
        wait_idle();
        n_checks++;
        if (pop_cyc.size() != 3) $display("FAIL pop_count: got %0d exp 3", pop_cyc.size());
        else n_pass++;
        if (pop_cyc.size() == 3) begin
            n_checks++;
            if (pop_cyc[1] - pop_cyc[0] != 3 || pop_cyc[2] - pop_cyc[1] != 3)
                $display("FAIL pop_spacing: got %0d,%0d exp 3,3", pop_cyc[1] - pop_cyc[0], pop_cyc[2] - pop_cyc[1]);
            else n_pass++;
        end
        n_checks++;
        if (key_held !== 1'b0 || key_code !== 8'h1C || cnt !== 8'd1)
            $display("FAIL press_a_final: held=%b code=%h cnt=%0d exp 0 1c 1", key_held, key_code, cnt);
        else n_pass++;
    endtask

    task automatic test_typematic();
        do_reset();
        send(8'h16); send(8'h16); send(8'h16); send(8'hF0); send(8'h16);
        wait_idle();
        n_checks++;
        if (ascii !== 8'h31 || cnt !== 8'd1 || key_held !== 1'b0)
            $display("FAIL typematic: ascii=%h cnt=%0d held=%b exp 31 1 0", ascii, cnt, key_held);
        else n_pass++;
        n_checks++;
        if (cnt_r !== 8'd3) $display("FAIL typematic_rep: cnt=%0d exp 3", cnt_r);
        else n_pass++;
    endtask

    task automatic test_extended();
        do_reset();
        send(8'hE0); send(8'h75); send(8'hF0); send(8'h75);
        wait_idle();
        n_checks++;
        if (key_ext !== 1'b1 || ascii !== 8'h00 || cnt !== 8'd1 || key_held !== 1'b1)
            $display("FAIL ext_mismatch: ext=%b ascii=%h cnt=%0d held=%b exp 1 00 1 1", key_ext, ascii, cnt, key_held);
        else n_pass++;
        send(8'hE0); send(8'hF0); send(8'h75);
        wait_idle();
        n_checks++;
        if (key_held !== 1'b0 || key_code !== 8'h75)
            $display("FAIL ext_release: held=%b code=%h exp 0 75", key_held, key_code);
        else n_pass++;
        send(8'h29);
        wait_idle();
        n_checks++;
        if (ascii !== 8'h20 || key_ext !== 1'b0)
            $display("FAIL space: ascii=%h ext=%b exp 20 0", ascii, key_ext);
        else n_pass++;
    endtask

    task automatic test_wrap_overflow();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send(8'h45); send(8'hF0); send(8'h45);
            wait_idle();
        end
        n_checks++;
        if (cnt !== 8'd0 || cnt_r !== 8'd0 || ascii !== 8'h30)
            $display("FAIL wrap: cnt=%0d cnt_r=%0d ascii=%h exp 0 0 30", cnt, cnt_r, ascii);
        else n_pass++;
        n_checks++;
        if (err_ov !== 1'b0) $display("FAIL ovf_idle: err=%b exp 0", err_ov);
        else n_pass++;
        ps2_overflow = 1'b1;
        @(negedge clk);
        #1;
        ps2_overflow = 1'b0;
        n_checks++;
        if (err_ov !== 1'b1) $display("FAIL ovf_set: err=%b exp 1", err_ov);
        else n_pass++;
        send(8'h1C);
        wait_idle();
        repeat (5) @(negedge clk);
        #1;
        n_checks++;
        if (err_ov !== 1'b1) $display("FAIL ovf_sticky: err=%b exp 1", err_ov);
        else n_pass++;
        do_reset();
        n_checks++;
        if (err_ov !== 1'b0) $display("FAIL ovf_clear: err=%b exp 0", err_ov);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        send(8'h1C); send(8'hF0);
        wait_idle();
        do_reset();
        send(8'h1C);
        wait_idle();
        n_checks++;
        if (key_held !== 1'b1 || cnt !== 8'd1 || key_code !== 8'h1C)
            $display("FAIL reset_mid: held=%b cnt=%0d code=%h exp 1 1 1c", key_held, cnt, key_code);
        else n_pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_press_a();
        test_typematic();
        test_extended();
        test_wrap_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_key_ctrl.md
Name: ps2_key_ctrl

Overview:
Sequencing controller between the PS/2 receive FIFO and the seven-segment display block. It pops scan-code bytes with a ready/next handshake and decodes set-2 make, break (F0) and extended (E0) prefixes. It holds the current key, its ASCII value and a key-press count in registers, and drives a display-enable flag, so the display path stays purely combinational.

Parameters:
COUNT_W, 8, width of press counter
REPEAT_COUNTS, 0, 1 = typematic repeats increment counter; 0 = they do not

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ps2_ready  in  1  FIFO non-empty; ps2_data valid
ps2_data  in  8  FIFO head byte
ps2_overflow  in  1  FIFO overflow indication
ps2_nextdata_n  out  1  active-low pop strobe to FIFO
key_code  out  8  last make code (non-prefix byte)
key_ext  out  1  last key was E0-extended
key_held  out  1  key currently pressed; display enable for code/ASCII digits
ascii  out  8  ASCII of key_code; 8'h00 if unmapped or extended
press_count  out  COUNT_W  number of new key presses, wraps
err_overflow  out  1  sticky overflow flag

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst), sampled on the clk rising edge; rst has priority over all other activity.
- Reset values: ps2_nextdata_n=1; key_code=0, key_ext=0, key_held=0, ascii=0, press_count=0, err_overflow=0. Internal break_pend=0, ext_pend=0, state=WAIT.
- FSM states: WAIT, POP, DECODE.
  - WAIT: if ps2_ready=1, latch ps2_data into rx_byte; drive ps2_nextdata_n=0 (registered); go to POP. Otherwise stay.
  - POP: ps2_nextdata_n returns to 1; go to DECODE.
  - DECODE: process rx_byte; go to WAIT.
  - ps2_nextdata_n is low for exactly one cycle per byte. Minimum 3 cycles per byte.
  - ps2_ready is ignored outside WAIT, so one FIFO entry is never popped twice.
- Decode of byte B in DECODE:
  - B=E0: ext_pend<=1. No other change.
  - B=F0: break_pend<=1. No other change.
  - Other B with break_pend=1 (release): if B==key_code and ext_pend==key_ext, key_held<=0. A release of a non-current key has no output effect. Clear break_pend and ext_pend. key_code, ascii and key_ext retain their values.
  - Other B with break_pend=0 (make):
    - New press (key_held=0, or B!=key_code, or ext_pend!=key_ext): key_code<=B, key_ext<=ext_pend, key_held<=1, press_count<=press_count+1.
    - Typematic repeat (key_held=1, B==key_code, ext_pend==key_ext): key_held stays 1; press_count increments only if REPEAT_COUNTS=1.
    - Clear ext_pend in both cases.
- Counter arithmetic: press_count is modulo 2^COUNT_W; all-ones wraps to 0, no saturation.
- ascii: registered and updated in the same cycle as key_code.
  - Set-2 letters map to lowercase (1C->61 'a', 32->62, 21->63 ... 1A->7A).
  - Digits map as 45->30, 16->31 ... 46->39; 29->20 (space).
  - Everything else, and any key_ext=1 code, maps to 00.
- err_overflow: set when ps2_overflow=1 in any cycle; cleared only by rst.
- Simultaneous events:
  - rst together with ps2_ready: reset wins and no pop is issued.
  - Overflow concurrent with decode: both take effect.
- Reset mid-operation: pending E0/F0 prefixes are discarded. A byte latched but not yet decoded is lost; the FIFO entry was already popped if POP had been reached.

Test Plan:
- Reset: assert rst 2 cycles with ps2_ready=1 -> all outputs at reset values; ps2_nextdata_n stays 1 throughout.
- Press/release 'a': FIFO bytes 1C, F0, 1C, ps2_ready held high -> after first DECODE: key_code=1C, ascii=61, key_held=1, press_count=1. After final DECODE: key_held=0, key_code=1C, press_count=1. ps2_nextdata_n low exactly 3 single cycles, each 3 cycles apart.
- Typematic: bytes 16,16,16,F0,16 with REPEAT_COUNTS=0 -> ascii=31, press_count=1, final key_held=0. Repeat with REPEAT_COUNTS=1 -> press_count=3.
- Extended and mismatched release: bytes E0,75,F0,75 -> key_ext=1, ascii=00, press_count=1. key_held stays 1 (non-E0 75 release ignored). Then E0,F0,75 -> key_held=0.
- Wrap and overflow: 256 press/release pairs of 45 -> press_count returns to 0. Pulse ps2_overflow one cycle -> err_overflow=1 until next rst.
- Reset mid-sequence: bytes 1C, F0, then rst, then 1C -> the post-reset 1C is treated as a make: key_held=1, press_count=1.
